// File: rtl/registrador_pkg.sv
// Shared definitions for the universal shift register: op-code width and
// constants, and the three-state controller encoding.
package registrador_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_HOLD  = 3'b000;
    localparam logic [OP_W-1:0] OP_LOAD  = 3'b001;
    localparam logic [OP_W-1:0] OP_CLEAR = 3'b010;
    localparam logic [OP_W-1:0] OP_SHL   = 3'b011;
    localparam logic [OP_W-1:0] OP_SHR   = 3'b100;
    localparam logic [OP_W-1:0] OP_SAR   = 3'b101;
    localparam logic [OP_W-1:0] OP_ROL   = 3'b110;
    localparam logic [OP_W-1:0] OP_ROR   = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/registrador_shift_step.sv
// One combinational shift/rotate step: (op, q, serial_in) -> (q_next, carry).
// Ops that are not shifts/rotates pass q through with carry 0.
module registrador_shift_step
    import registrador_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] q,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q_next,
    output logic             carry
);

    // Neighbour-bit vectors: up_core[i] = q[i-1], down_core[i] = q[i+1];
    // the vacated end bit is 0 here and filled per op below.
    logic [WIDTH-1:0] up_core;
    logic [WIDTH-1:0] down_core;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bits
            if (gi == 0) begin : g_lsb
                assign up_core[gi]   = 1'b0;
                assign down_core[gi] = q[gi+1];
            end else if (gi == WIDTH - 1) begin : g_msb
                assign up_core[gi]   = q[gi-1];
                assign down_core[gi] = 1'b0;
            end else begin : g_mid
                assign up_core[gi]   = q[gi-1];
                assign down_core[gi] = q[gi+1];
            end
        end
    endgenerate

    // Select the fill bit and the bit that leaves the register for each op.
    always_comb begin
        q_next = q;
        carry  = 1'b0;
        case (op)
            OP_SHL: begin
                q_next = {up_core[WIDTH-1:1], serial_in};
                carry  = q[WIDTH-1];
            end
            OP_SHR: begin
                q_next = {serial_in, down_core[WIDTH-2:0]};
                carry  = q[0];
            end
            OP_SAR: begin
                q_next = {q[WIDTH-1], down_core[WIDTH-2:0]};
                carry  = q[0];
            end
            OP_ROL: begin
                q_next = {up_core[WIDTH-1:1], q[WIDTH-1]};
                carry  = q[WIDTH-1];
            end
            OP_ROR: begin
                q_next = {q[0], down_core[WIDTH-2:0]};
                carry  = q[0];
            end
            default: begin
                q_next = q;
                carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/registrador_universal.sv
// Universal register: load/clear/hold in one command cycle, multi-cycle
// shifts and rotates driven by a small IDLE/SHIFT/DONE controller.
// Optional feature macro: REGISTRADOR_UNIVERSAL_ZERO_FLAG_EN adds a
// combinational zero flag output (zero = Q == 0).
module registrador_universal
    import registrador_pkg::*;
#(
    parameter int WIDTH   = 8,
    localparam int SHAMT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [OP_W-1:0]    op,
    input  logic [WIDTH-1:0]   D,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               serial_in,
    output logic [WIDTH-1:0]   Q,
`ifdef REGISTRADOR_UNIVERSAL_ZERO_FLAG_EN
    output logic               zero,
`endif
    output logic               busy,
    output logic               done,
    output logic               carry_out
);

    localparam logic [SHAMT_W-1:0] WIDTH_CNT = SHAMT_W'(WIDTH);

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   q_reg, q_next;
    logic               carry_reg, carry_next;
    logic [SHAMT_W-1:0] cnt_reg, cnt_next;
    logic [OP_W-1:0]    op_reg, op_next;

    logic [WIDTH-1:0]   step_q;
    logic               step_carry;

    // The step unit always works on the latched op so later changes on op are harmless.
    registrador_shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .op       (op_reg),
        .q        (q_reg),
        .serial_in(serial_in),
        .q_next   (step_q),
        .carry    (step_carry)
    );

    // State and datapath registers; active-low synchronous reset aborts any command.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            q_reg     <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            op_reg    <= OP_HOLD;
        end else begin
            state_reg <= state_next;
            q_reg     <= q_next;
            carry_reg <= carry_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
        end
    end

    // Next-state and datapath updates; every register holds unless an action applies.
    always_comb begin
        state_next = state_reg;
        q_next     = q_reg;
        carry_next = carry_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_HOLD: begin
                            state_next = DONE;
                        end
                        OP_LOAD: begin
                            q_next     = D;
                            state_next = DONE;
                        end
                        OP_CLEAR: begin
                            q_next     = '0;
                            carry_next = 1'b0;
                            state_next = DONE;
                        end
                        default: begin
                            // Shift/rotate: latch the command, count clamped to WIDTH.
                            op_next    = op;
                            cnt_next   = (shamt > WIDTH_CNT) ? WIDTH_CNT : shamt;
                            state_next = SHIFT;
                        end
                    endcase
                end
            end
            SHIFT: begin
                if (cnt_reg != '0) begin
                    q_next     = step_q;
                    carry_next = step_carry;
                    cnt_next   = cnt_reg - 1'b1;
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign Q         = q_reg;
    assign carry_out = carry_reg;
    assign busy      = (state_reg == SHIFT);
    assign done      = (state_reg == DONE);

`ifdef REGISTRADOR_UNIVERSAL_ZERO_FLAG_EN
    assign zero = (q_reg == '0);
`endif

endmodule

// File: tb/tb_registrador_universal.sv
// Self-checking bench for registrador_universal (WIDTH=8): a scoreboard of
// expected step values and final results is filled when each command is
// issued and drained as the DUT shifts and signals done.
module tb_registrador_universal;
    import registrador_pkg::*;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op = 3'b000;
    logic [7:0] D = 8'h00;
    logic [3:0] shamt = 4'h0;
    logic       serial_in = 1'b0;
    logic [7:0] Q;
    logic       busy;
    logic       done;
    logic       carry_out;
`ifdef REGISTRADOR_UNIVERSAL_ZERO_FLAG_EN
    logic       zero;
`endif

    registrador_universal #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .D        (D),
        .shamt    (shamt),
        .serial_in(serial_in),
        .Q        (Q),
`ifdef REGISTRADOR_UNIVERSAL_ZERO_FLAG_EN
        .zero     (zero),
`endif
        .busy     (busy),
        .done     (done),
        .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic       c;
        int         busy_cycles;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] step_q[$];

    int n_checks = 0;
    int n_passed = 0;

    logic [7:0] model_q = 8'h00;
    logic       model_c = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end else begin
            n_passed++;
        end
    endtask

    // Reference step: returns {carry, q} built from a 9-bit extended word.
    function automatic logic [8:0] model_step(input logic [2:0] m_op, input logic [7:0] q,
                                              input logic sin);
        logic [8:0] t;
        case (m_op)
            OP_SHL: begin t = {q, sin};  return {t[8], t[7:0]}; end
            OP_SHR: begin t = {sin, q};  return {t[0], t[8:1]}; end
            OP_SAR: begin t = {q[7], q}; return {t[0], t[8:1]}; end
            OP_ROL: begin t = {q, q[7]}; return {t[8], t[7:0]}; end
            OP_ROR: begin t = {q[0], q}; return {t[0], t[8:1]}; end
            default: return {1'b0, q};
        endcase
    endfunction

    task automatic run_cmd(input logic [2:0] c_op, input logic [7:0] c_d, input logic [3:0] c_sh,
                           input logic c_sin, input bit inject, input string tag);
        exp_t       r;
        logic [8:0] s;
        int         n;
        int         busy_seen;
        bit         got_done;
        // Fill the scoreboard from the model before driving the DUT.
        r.q = model_q;
        r.c = model_c;
        r.busy_cycles = 0;
        if (c_op == OP_LOAD) begin
            r.q = c_d;
        end else if (c_op == OP_CLEAR) begin
            r.q = 8'h00;
            r.c = 1'b0;
        end else if (c_op != OP_HOLD) begin
            n = (int'(c_sh) > W) ? W : int'(c_sh);
            for (int i = 0; i < n; i++) begin
                s   = model_step(c_op, r.q, c_sin);
                r.q = s[7:0];
                r.c = s[8];
                step_q.push_back(r.q);
            end
            r.busy_cycles = n + 1;
        end
        exp_q.push_back(r);
        model_q = r.q;
        model_c = r.c;

        @(negedge clk);
        start = 1'b1; op = c_op; D = c_d; shamt = c_sh; serial_in = c_sin;
        @(posedge clk); #1;
        // Scramble command inputs after acceptance; serial_in stays put.
        start = 1'b0; op = 3'($urandom); D = 8'($urandom); shamt = 4'($urandom);
        busy_seen = 0;
        got_done  = 1'b0;
        for (int cyc = 0; cyc < 40 && !got_done; cyc++) begin
            if (done) begin
                got_done = 1'b1;
            end else begin
                if (busy) begin
                    if (busy_seen > 0) begin
                        if (step_q.size() > 0) check({tag, " step"}, 32'(Q), 32'(step_q.pop_front()));
                        else check({tag, " extra_step"}, 32'(busy_seen), 32'(0));
                    end
                    busy_seen++;
                    if (inject && busy_seen == 2) begin
                        start = 1'b1; op = OP_LOAD; D = 8'hFF;
                    end
                end
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        check({tag, " done_seen"}, 32'(got_done), 32'(1));
        check({tag, " steps_left"}, 32'(step_q.size()), 32'(0));
        step_q.delete();
        r = exp_q.pop_front();
        check({tag, " Q"}, 32'(Q), 32'(r.q));
        check({tag, " carry"}, 32'(carry_out), 32'(r.c));
        check({tag, " busy_cycles"}, 32'(busy_seen), 32'(r.busy_cycles));
`ifdef REGISTRADOR_UNIVERSAL_ZERO_FLAG_EN
        check({tag, " zero"}, 32'(zero), 32'(r.q == 8'h00));
`endif
        @(posedge clk); #1;
        check({tag, " done_once"}, 32'(done), 32'(0));
        check({tag, " idle_busy"}, 32'(busy), 32'(0));
        $display("cmd %-10s op=%0d D=%02h shamt=%0d sin=%0b -> Q=%02h carry=%0b busy=%0d",
                 tag, c_op, c_d, c_sh, c_sin, Q, carry_out, busy_seen);
    endtask

    initial begin
        int done_cnt;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("por Q", 32'(Q), 32'(0));
        check("por busy", 32'(busy), 32'(0));
        @(negedge clk);
        rst = 1'b1;

        // Reset from a loaded value
        run_cmd(OP_LOAD, 8'hA5, 4'd0, 1'b0, 1'b0, "load_a5");
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("rst Q", 32'(Q), 32'(0));
        check("rst busy", 32'(busy), 32'(0));
        check("rst done", 32'(done), 32'(0));
        check("rst carry", 32'(carry_out), 32'(0));
`ifdef REGISTRADOR_UNIVERSAL_ZERO_FLAG_EN
        check("rst zero", 32'(zero), 32'(1));
`endif
        $display("reset    Q=%02h busy=%0b done=%0b carry=%0b", Q, busy, done, carry_out);
        model_q = 8'h00; model_c = 1'b0;
        @(negedge clk); rst = 1'b1;

        run_cmd(OP_LOAD,  8'h3C, 4'd0, 1'b0, 1'b0, "load_3c");
        run_cmd(OP_LOAD,  8'h81, 4'd0, 1'b0, 1'b0, "load_81");
        run_cmd(OP_SHL,   8'h00, 4'd3, 1'b1, 1'b0, "shl3");
        run_cmd(OP_LOAD,  8'h90, 4'd0, 1'b0, 1'b0, "load_90");
        run_cmd(OP_SAR,   8'h00, 4'd2, 1'b0, 1'b0, "sar2");
        run_cmd(OP_LOAD,  8'h01, 4'd0, 1'b0, 1'b0, "load_01");
        run_cmd(OP_ROR,   8'h00, 4'd9, 1'b0, 1'b1, "ror9_inj");
        run_cmd(OP_LOAD,  8'hB6, 4'd0, 1'b0, 1'b0, "load_b6");
        run_cmd(OP_ROL,   8'h00, 4'd0, 1'b1, 1'b0, "rol0");
        run_cmd(OP_SHR,   8'h00, 4'd8, 1'b1, 1'b0, "shr8");
        run_cmd(OP_HOLD,  8'h12, 4'd0, 1'b0, 1'b0, "hold");
        run_cmd(OP_CLEAR, 8'h34, 4'd0, 1'b0, 1'b0, "clear");
        for (int i = 0; i < 12; i++) begin
            run_cmd(3'($urandom), 8'($urandom), 4'($urandom_range(0, 15)),
                    1'($urandom), 1'b0, "random");
        end

        // Abort a shift in its second SHIFT cycle
        run_cmd(OP_LOAD, 8'h5A, 4'd0, 1'b0, 1'b0, "load_5a");
        @(negedge clk);
        start = 1'b1; op = OP_SHL; D = 8'h00; shamt = 4'd5; serial_in = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("abort busy1", 32'(busy), 32'(1));
        @(posedge clk); #1;
        check("abort step1", 32'(Q), 32'(8'hB5));
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort Q", 32'(Q), 32'(0));
        check("abort busy", 32'(busy), 32'(0));
        check("abort done", 32'(done), 32'(0));
        check("abort carry", 32'(carry_out), 32'(0));
`ifdef REGISTRADOR_UNIVERSAL_ZERO_FLAG_EN
        check("abort zero", 32'(zero), 32'(1));
`endif
        rst = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done || busy) done_cnt++;
        end
        check("abort no_done", 32'(done_cnt), 32'(0));
        check("abort Q_hold", 32'(Q), 32'(0));
        $display("abort    Q=%02h busy=%0b done=%0b", Q, busy, done);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
